// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] ECALL_INSTR = 32'h0000_0073;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // Sequential next address; wraps silently past the top of the address space.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

    // Word-align a byte address by clearing bits [1:0].
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if;
    import riscv_fetch_pkg::*;

    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry capture/replay buffer that keeps a fetched instruction alive across a stall.
module fetch_hold_buf
    import riscv_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               clear,
    input  logic [INSTR_W-1:0] din,
    output logic               hold_valid_q,
    output logic [INSTR_W-1:0] hold_instr_q
);

    logic               hold_valid_d;
    logic [INSTR_W-1:0] hold_instr_d;

    // Clear wins so a redirect or release never replays a stale word.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        if (clear) begin
            hold_valid_d = 1'b0;
        end else if (capture) begin
            hold_valid_d = 1'b1;
            hold_instr_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// presents {PC, PC+4, instruction, ECALL} to the IF/ID register every cycle.
module if_fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                resume,
    if_fetch_stage_if.master    imem,
    output logic [PC_W-1:0]     PC_IF_IFID,
    output logic [PC_W-1:0]     PC_plus4_IF_out,
    output logic [INSTR_W-1:0]  instruction_IF_IFID,
    output logic                ECALL_IF_IFID,
    output logic                instr_valid_IF_IFID
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            resp_valid_q, resp_valid_d;
    logic [PC_W-1:0] resp_pc_q, resp_pc_d;

    logic               hold_valid_q;
    logic [INSTR_W-1:0] hold_instr_q;
    logic               hold_capture;
    logic               hold_clear;

    logic               issue;
    logic [PC_W-1:0]    issue_addr;
    logic [INSTR_W-1:0] present_instr;
    logic               present_valid;
    logic               present_ecall;
    logic               ecall_take;

    fetch_hold_buf u_hold_buf (
        .clk          (clk),
        .rst          (rst),
        .capture      (hold_capture),
        .clear        (hold_clear),
        .din          (imem.imem_rdata),
        .hold_valid_q (hold_valid_q),
        .hold_instr_q (hold_instr_q)
    );

    // Request issue and presentation of the response of the previous request.
    always_comb begin
        issue         = !rst && ((state_q == FETCH && !stall) || redirect_valid);
        issue_addr    = redirect_valid ? align_word(redirect_pc) : pc_q;
        present_instr = hold_valid_q ? hold_instr_q : imem.imem_rdata;
        present_valid = (resp_valid_q || hold_valid_q) && !redirect_valid && (state_q == FETCH);
        present_ecall = present_valid && (present_instr == ECALL_INSTR);
        ecall_take    = present_ecall && !stall;
    end

    assign imem.imem_rd_en     = issue;
    assign imem.imem_addr      = issue_addr;
    assign PC_IF_IFID          = resp_pc_q;
    assign PC_plus4_IF_out     = pc_next(resp_pc_q);
    assign instruction_IF_IFID = present_valid ? present_instr : NOP_INSTR;
    assign ECALL_IF_IFID       = present_ecall;
    assign instr_valid_IF_IFID = present_valid;

    // The request issued alongside a taken ECALL is dropped, so pc_q keeps ECALL PC+4.
    always_comb begin
        pc_d         = pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        state_d      = state_q;

        if (issue && !ecall_take) begin
            pc_d         = pc_next(issue_addr);
            resp_pc_d    = issue_addr;
            resp_valid_d = 1'b1;
        end else if (!stall || ecall_take) begin
            resp_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            state_d = FETCH;
        end else if (ecall_take) begin
            state_d = HALTED;
        end else if (state_q == HALTED && resume) begin
            state_d = FETCH;
        end

        hold_capture = stall && !redirect_valid && (state_q == FETCH)
                       && resp_valid_q && !hold_valid_q;
        hold_clear   = hold_valid_q && (!stall || redirect_valid || state_q != FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

endmodule
